scc_register_writer: RTL and testbench
======================================

Name: scc_register_writer

Overview:
- Write side of the wave-table channel register file: decodes host register writes into six per-channel register sets (A–F).
- Drives the channel scan index `active` that downstream read-side logic uses to pick one channel's registers per cycle.
- Writes aimed at the channel currently being scanned are deferred through a one-entry pending buffer, so a channel's registers never change during its own scan slot.
- Sits between the bus interface and the tone generators.

Parameters:
- CH_COUNT, 6, number of channels; fixed at 6, `active` wraps at CH_COUNT-1.
- BASE_ADDR, 8'h80, first address of the register window.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- wr  input  1  write request, qualified by ready
- address  input  8  register address
- wdata  input  8  write data
- ready  output  1  write accepted on any cycle where wr & ready
- active  output  3  current scan channel, 0..5
- freq_a..freq_f  output  12 each  channel frequency divider
- vol_a..vol_f  output  4 each  channel volume
- enable  output  6  key-on mask, bit n = channel n
- freq_reset  output  6  one-cycle pulse, bit n = channel n frequency written (phase restart)

Behaviour:
- Reset (sync, active-high, synchronous to clk):
  - all freq, vol, enable and freq_reset = 0
  - active = 0, ready = 1, pending buffer empty
  - any pending write is discarded
- Scan counter:
  - active increments every cycle, 0,1,2,3,4,5,0,...
  - never holds; not affected by writes
- Address map (offset = address - BASE_ADDR):
  - 0x00+2n: freq_n[7:0] = wdata
  - 0x01+2n: freq_n[11:8] = wdata[3:0] (n = 0..5, offsets 0x00–0x0B)
  - 0x0C+n: vol_n = wdata[3:0] (offsets 0x0C–0x11)
  - 0x12: enable = wdata[5:0]
  - Any other address: accepted (ready behaviour unchanged) and ignored, with no register change and no pulse.
  - Unused wdata bits are ignored.
- Target channel:
  - freq/vol writes target channel n.
  - enable and ignored writes have no target and commit immediately.
- Accept, no conflict (target != active in the accept cycle, or no target):
  - register updates at the accepting edge; new value visible the next cycle
  - freq_reset[n] pulses that same next cycle, for freq writes only
- Accept, conflict (target == active in the accept cycle):
  - address and data are stored in the pending buffer; ready = 0 the next cycle
  - the commit happens on the first cycle where active != target, which is always the next cycle
  - the register is visible 2 cycles after accept, freq_reset likewise
  - ready returns to 1 the cycle after the commit
- wr while ready = 0 is ignored; the host must hold or retry.
- No two writes are ever committed in one cycle.
- freq_reset pulse width is exactly 1 cycle.
- Back-to-back writes to the same freq register each pulse.
- Write to the volume of a disabled channel still updates vol_n.

Optional Feature:
- SCC_FREQ_LATCH_EN defined:
  - low-byte freq writes go to a per-channel 8-bit shadow only, with no output change and no pulse
  - the high-nibble write commits {wdata[3:0], shadow} atomically, with one freq_reset pulse
  - the shadow is cleared by reset
  - the conflict/pending rules apply to the high-byte commit
- SCC_FREQ_LATCH_EN undefined:
  - each byte write updates its half immediately and pulses freq_reset

Test Plan:
- Reset check: reset for 2 cycles, then release.
  - During reset: freq_* = 0, vol_* = 0, enable = 0, ready = 1, active = 0.
  - After release: active counts 0..5,0.
- Non-conflicting write: with active = 2, write 0x80 <= 0x34.
  - freq_a = 0x034 next cycle; freq_reset = 6'b000001 for 1 cycle; ready stays 1.
- Conflicting write: with active = 3, write 0x8F <= 0xFA (vol_d).
  - Next cycle: ready = 0, vol_d still 0.
  - Following cycle: vol_d = 0xA.
  - Cycle after that: ready = 1.
  - A wr asserted while ready = 0 (0x8C <= 0x5) changes nothing.
- Enable and out-of-range: write 0x92 <= 0xFF → enable = 6'h3F.
  - Write 0x93 <= 0x55 and 0x7F <= 0x55 → no output change, no pulse.
- Reset mid-operation: conflicting write to 0x8B, then reset on the next cycle.
  - freq_f remains 0 and the pending write is lost.
  - ready = 1 and active = 0 after reset.
- Frequency latching: write 0x84 <= 0xCD, then 0x85 <= 0x1B.
  - SCC_FREQ_LATCH_EN defined: freq_c stays 0 after the first write, then becomes 0xBCD with a single pulse.
  - SCC_FREQ_LATCH_EN undefined: freq_c = 0x0CD, then 0xBCD, with two pulses.

Source files
------------

// File: rtl/scc_register_writer.sv
// Write side of the wave-table channel register file: host writes -> six channel register sets.
// Optional SCC_FREQ_LATCH_EN: low freq byte goes to a shadow, high nibble commits both halves.
module scc_register_writer #(
    parameter int           CH_COUNT  = 6,
    parameter logic [7:0]   BASE_ADDR = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [7:0]  address,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic [2:0]  active,
    output logic [11:0] freq_a,
    output logic [11:0] freq_b,
    output logic [11:0] freq_c,
    output logic [11:0] freq_d,
    output logic [11:0] freq_e,
    output logic [11:0] freq_f,
    output logic [3:0]  vol_a,
    output logic [3:0]  vol_b,
    output logic [3:0]  vol_c,
    output logic [3:0]  vol_d,
    output logic [3:0]  vol_e,
    output logic [3:0]  vol_f,
    output logic [5:0]  enable,
    output logic [5:0]  freq_reset
);

    // Returns {has_target, channel} for a register-window offset.
    function automatic logic [3:0] decode_target(input logic [7:0] off);
        logic [7:0] rel;
        rel = off - 8'h0C;
        if (off < 8'h0C) begin
`ifdef SCC_FREQ_LATCH_EN
            // Low-byte writes only touch the shadow, which nothing scans.
            return off[0] ? {1'b1, off[3:1]} : 4'b0000;
`else
            return {1'b1, off[3:1]};
`endif
        end else if (off < 8'h12) begin
            return {1'b1, rel[2:0]};
        end
        return 4'b0000;
    endfunction

    logic [2:0]  active_q, active_d;
    logic        ready_q, ready_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_off_q;
    logic [7:0]  pend_data_q;
    logic [2:0]  pend_ch_q;
    logic [11:0] freq_q [CH_COUNT];
    logic [11:0] freq_nx [CH_COUNT];
    logic [3:0]  vol_q [CH_COUNT];
    logic [3:0]  vol_nx [CH_COUNT];
    logic [5:0]  enable_q, enable_d;
    logic [5:0]  freq_reset_q, freq_reset_d;
`ifdef SCC_FREQ_LATCH_EN
    logic [7:0]  shadow_q [CH_COUNT];
    logic [7:0]  shadow_d [CH_COUNT];
`endif

    logic [7:0]  acc_off;
    logic [3:0]  acc_tgt;
    logic        accept, conflict, pend_go, commit_vld;
    logic [7:0]  commit_off, commit_data, vol_rel;
    logic [2:0]  commit_ch;

    assign accept   = wr & ready_q;
    assign acc_off  = address - BASE_ADDR;
    assign acc_tgt  = decode_target(acc_off);
    assign conflict = accept & acc_tgt[3] & (acc_tgt[2:0] == active_q);
    // ready is low while a write is parked, so the two commit sources never collide.
    assign pend_go     = pend_vld_q & (pend_ch_q != active_q);
    assign commit_vld  = pend_go | (accept & ~conflict);
    assign commit_off  = pend_go ? pend_off_q  : acc_off;
    assign commit_data = pend_go ? pend_data_q : wdata;
    assign commit_ch   = commit_off[3:1];
    assign vol_rel     = commit_off - 8'h0C;

    always_comb begin
        active_d = (active_q == 3'(CH_COUNT - 1)) ? 3'd0 : active_q + 3'd1;
        ready_d    = ready_q;
        pend_vld_d = pend_vld_q;
        if (conflict) begin
            ready_d    = 1'b0;
            pend_vld_d = 1'b1;
        end else if (pend_go) begin
            ready_d    = 1'b1;
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        freq_nx      = freq_q;
        vol_nx       = vol_q;
        enable_d     = enable_q;
        freq_reset_d = '0;
`ifdef SCC_FREQ_LATCH_EN
        shadow_d     = shadow_q;
`endif
        if (commit_vld) begin
            if (commit_off < 8'h0C) begin
`ifdef SCC_FREQ_LATCH_EN
                if (!commit_off[0]) begin
                    shadow_d[commit_ch] = commit_data;
                end else begin
                    freq_nx[commit_ch]      = {commit_data[3:0], shadow_q[commit_ch]};
                    freq_reset_d[commit_ch] = 1'b1;
                end
`else
                if (!commit_off[0]) begin
                    freq_nx[commit_ch][7:0]  = commit_data;
                end else begin
                    freq_nx[commit_ch][11:8] = commit_data[3:0];
                end
                freq_reset_d[commit_ch] = 1'b1;
`endif
            end else if (commit_off < 8'h12) begin
                vol_nx[vol_rel[2:0]] = commit_data[3:0];
            end else if (commit_off == 8'h12) begin
                enable_d = commit_data[5:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q     <= '0;
            ready_q      <= 1'b1;
            pend_vld_q   <= 1'b0;
            enable_q     <= '0;
            freq_reset_q <= '0;
            for (int i = 0; i < CH_COUNT; i++) begin
                freq_q[i] <= '0;
                vol_q[i]  <= '0;
`ifdef SCC_FREQ_LATCH_EN
                shadow_q[i] <= '0;
`endif
            end
        end else begin
            active_q     <= active_d;
            ready_q      <= ready_d;
            pend_vld_q   <= pend_vld_d;
            enable_q     <= enable_d;
            freq_reset_q <= freq_reset_d;
            freq_q       <= freq_nx;
            vol_q        <= vol_nx;
`ifdef SCC_FREQ_LATCH_EN
            shadow_q     <= shadow_d;
`endif
        end
    end

    // Pending payload needs no reset: it is only used while pend_vld_q is set.
    always_ff @(posedge clk) begin
        if (conflict) begin
            pend_off_q  <= acc_off;
            pend_data_q <= wdata;
            pend_ch_q   <= acc_tgt[2:0];
        end
    end

    assign ready      = ready_q;
    assign active     = active_q;
    assign enable     = enable_q;
    assign freq_reset = freq_reset_q;
    assign freq_a = freq_q[0];
    assign freq_b = freq_q[1];
    assign freq_c = freq_q[2];
    assign freq_d = freq_q[3];
    assign freq_e = freq_q[4];
    assign freq_f = freq_q[5];
    assign vol_a  = vol_q[0];
    assign vol_b  = vol_q[1];
    assign vol_c  = vol_q[2];
    assign vol_d  = vol_q[3];
    assign vol_e  = vol_q[4];
    assign vol_f  = vol_q[5];

endmodule

// File: tb/tb_scc_register_writer.sv
// Directed bench for scc_register_writer; inputs driven and outputs sampled on the falling edge.
module tb_scc_register_writer;

    logic        clk = 1'b0;
    logic        reset, wr, ready;
    logic [7:0]  address, wdata;
    logic [2:0]  active;
    logic [11:0] freq_a, freq_b, freq_c, freq_d, freq_e, freq_f;
    logic [3:0]  vol_a, vol_b, vol_c, vol_d, vol_e, vol_f;
    logic [5:0]  enable, freq_reset;
    int          errors = 0;
    int          checks = 0;

    scc_register_writer dut (
        .clk(clk), .reset(reset), .wr(wr), .address(address), .wdata(wdata),
        .ready(ready), .active(active),
        .freq_a(freq_a), .freq_b(freq_b), .freq_c(freq_c),
        .freq_d(freq_d), .freq_e(freq_e), .freq_f(freq_f),
        .vol_a(vol_a), .vol_b(vol_b), .vol_c(vol_c),
        .vol_d(vol_d), .vol_e(vol_e), .vol_f(vol_f),
        .enable(enable), .freq_reset(freq_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at a falling edge where active == v.
    task automatic wait_active(input logic [2:0] v);
        int n = 0;
        while (active !== v && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("wait_active", 16'(active), 16'(v));
    endtask

    // Drive one write for one cycle; returns at the falling edge after the accepting edge.
    task automatic write(input logic [7:0] a, input logic [7:0] d);
        wr      = 1'b1;
        address = a;
        wdata   = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; wr = 1'b0; address = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 16'(ready), 16'h1);
        check("rst_active", 16'(active), 16'h0);
        check("rst_freq_a", 16'(freq_a), 16'h0);
        check("rst_freq_f", 16'(freq_f), 16'h0);
        check("rst_vol_a", 16'(vol_a), 16'h0);
        check("rst_vol_f", 16'(vol_f), 16'h0);
        check("rst_enable", 16'(enable), 16'h0);
        check("rst_freq_reset", 16'(freq_reset), 16'h0);

        reset = 1'b0;
        check("scan_0", 16'(active), 16'h0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("scan_seq", 16'(active), 16'(i % 6));
        end

        // Non-conflicting freq low byte to channel a while channel 2 is scanned.
        wait_active(3'd2);
        write(8'h80, 8'h34);
`ifdef SCC_FREQ_LATCH_EN
        check("nc_freq_a", 16'(freq_a), 16'h000);
        check("nc_pulse", 16'(freq_reset), 16'h00);
`else
        check("nc_freq_a", 16'(freq_a), 16'h034);
        check("nc_pulse", 16'(freq_reset), 16'h01);
`endif
        check("nc_ready", 16'(ready), 16'h1);
        @(negedge clk);
        check("nc_pulse_end", 16'(freq_reset), 16'h00);

        // Conflicting vol_d write, plus a write attempt while ready is low.
        wait_active(3'd3);
        write(8'h8F, 8'hFA);
        check("cf_ready_low", 16'(ready), 16'h0);
        check("cf_vol_d_old", 16'(vol_d), 16'h0);
        write(8'h8C, 8'h05);
        check("cf_vol_d_new", 16'(vol_d), 16'hA);
        check("cf_vol_a_ign", 16'(vol_a), 16'h0);
        check("cf_no_pulse", 16'(freq_reset), 16'h00);
        @(negedge clk);
        check("cf_ready_back", 16'(ready), 16'h1);
        check("cf_vol_a_still", 16'(vol_a), 16'h0);

        // Enable register and ignored addresses.
        write(8'h92, 8'hFF);
        check("en_mask", 16'(enable), 16'h3F);
        write(8'h93, 8'h55);
        check("ign93_enable", 16'(enable), 16'h3F);
        check("ign93_pulse", 16'(freq_reset), 16'h00);
        check("ign93_ready", 16'(ready), 16'h1);
        write(8'h7F, 8'h55);
        check("ign7f_pulse", 16'(freq_reset), 16'h00);
        check("ign7f_vol_a", 16'(vol_a), 16'h0);
        check("ign7f_vol_d", 16'(vol_d), 16'hA);

        // Conflicting freq_f write interrupted by reset: the parked write is dropped.
        wait_active(3'd5);
        write(8'h8B, 8'h0F);
        check("mr_ready_low", 16'(ready), 16'h0);
        reset = 1'b1;
        @(negedge clk);
        check("mr_freq_f", 16'(freq_f), 16'h0);
        check("mr_ready", 16'(ready), 16'h1);
        check("mr_active", 16'(active), 16'h0);
        check("mr_enable", 16'(enable), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_freq_f_after", 16'(freq_f), 16'h0);
        check("mr_pulse_after", 16'(freq_reset), 16'h00);

        // Frequency byte pair to channel c, no conflicts (accepts at active 0 then 1).
        wait_active(3'd0);
        write(8'h84, 8'hCD);
`ifdef SCC_FREQ_LATCH_EN
        check("lt_lo_freq_c", 16'(freq_c), 16'h000);
        check("lt_lo_pulse", 16'(freq_reset), 16'h00);
`else
        check("lt_lo_freq_c", 16'(freq_c), 16'h0CD);
        check("lt_lo_pulse", 16'(freq_reset), 16'h04);
`endif
        write(8'h85, 8'h1B);
        check("lt_hi_freq_c", 16'(freq_c), 16'hBCD);
        check("lt_hi_pulse", 16'(freq_reset), 16'h04);
        @(negedge clk);
        check("lt_pulse_end", 16'(freq_reset), 16'h00);

        // Conflicting high-nibble write to channel c: value and pulse land two cycles later.
        wait_active(3'd2);
        write(8'h85, 8'h02);
        check("fc_ready_low", 16'(ready), 16'h0);
        check("fc_freq_c_old", 16'(freq_c), 16'hBCD);
        check("fc_no_pulse_yet", 16'(freq_reset), 16'h00);
        @(negedge clk);
        check("fc_freq_c_new", 16'(freq_c), 16'h2CD);
        check("fc_pulse", 16'(freq_reset), 16'h04);
        @(negedge clk);
        check("fc_pulse_end", 16'(freq_reset), 16'h00);
        check("fc_ready_back", 16'(ready), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
